// File: rtl/base_conv_pkg.sv
// Shared constants and FSM state type for the base-conversion datapath.
// Used by the nines-complement EEPROM fetch sequencer, the EEPROM model and the converter.
package base_conv_pkg;

  localparam int ROM_ADDR_W  = 16;
  localparam int ROM_DATA_W  = 8;
  localparam int ENTRY_BYTES = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/nines_rom_fetch.sv
// Read sequencer for the nines-complement EEPROM: fetches ENTRY_BYTES consecutive
// bytes of one table entry and presents them as a single word on a valid/ready port.
module nines_rom_fetch #(
  parameter int ADDR_W      = base_conv_pkg::ROM_ADDR_W,
  parameter int DATA_W      = base_conv_pkg::ROM_DATA_W,
  parameter int ENTRY_BYTES = base_conv_pkg::ENTRY_BYTES,
  parameter int INDEX_W     = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INDEX_W-1:0]            in_index,
  output logic                          rom_cs_n,
  output logic                          rom_oe_n,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [DATA_W-1:0]             rom_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ENTRY_BYTES*DATA_W-1:0] out_word,
  output logic                          busy
);

  import base_conv_pkg::*;

  localparam int WORD_W = ENTRY_BYTES * DATA_W;
  localparam int BCNT_W = (ENTRY_BYTES > 1) ? $clog2(ENTRY_BYTES) : 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(ENTRY_BYTES - 1);
  localparam logic [3:0]        WAIT_LAST = 4'(WAIT_CYCLES);

  fetch_state_t        r_state;
  logic [3:0]          r_wait_cnt;
  logic [BCNT_W-1:0]   r_byte_cnt;
  logic [WORD_W-1:0]   r_shadow;
  logic [WORD_W-1:0]   r_out_word;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_cs_n;
  logic                r_oe_n;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_out_valid;

  logic [ADDR_W-1:0]   w_base;
  logic [WORD_W-1:0]   w_shadow_next;
  logic                w_accept;

  // Entry base address, deliberately truncated to the EEPROM address width.
  always_comb begin
    w_base   = ADDR_W'(in_index) * ADDR_W'(ENTRY_BYTES);
    w_accept = in_valid && r_in_ready;
  end

  // Shadow word with the current byte lane replaced by the bus value.
  always_comb begin
    w_shadow_next = r_shadow;
    w_shadow_next[int'(r_byte_cnt)*DATA_W +: DATA_W] = rom_data;
  end

  // Fetch FSM with all EEPROM-side and downstream outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wait_cnt  <= 4'd0;
      r_byte_cnt  <= '0;
      r_shadow    <= '0;
      r_out_word  <= '0;
      r_addr      <= '0;
      r_cs_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr     <= w_base;
            r_cs_n     <= 1'b0;
            r_oe_n     <= 1'b0;
            r_byte_cnt <= '0;
            r_wait_cnt <= 4'd0;
            r_shadow   <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= READ;
          end
        end
        READ: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_shadow <= w_shadow_next;
            if (r_byte_cnt == LAST_BYTE) begin
              r_out_word  <= w_shadow_next;
              r_out_valid <= 1'b1;
              r_cs_n      <= 1'b1;
              r_oe_n      <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
              r_addr     <= r_addr + ADDR_W'(1);
              r_wait_cnt <= 4'd0;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        DONE: begin
          // out_word deliberately keeps its value after the handshake.
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cs_n      <= 1'b1;
          r_oe_n      <= 1'b1;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign rom_cs_n  = r_cs_n;
  assign rom_oe_n  = r_oe_n;
  assign rom_addr  = r_addr;
  assign out_valid = r_out_valid;
  assign out_word  = r_out_word;
  assign busy      = r_busy;

endmodule

// File: doc/nines_rom_fetch.md
Name: nines_rom_fetch

Overview:
- Read sequencer directly upstream of the nines-complement EEPROM in the base-conversion datapath.
- Takes a table index and drives the EEPROM's active-low chip select, active-low output enable and 16-bit address.
- Reads the ENTRY_BYTES consecutive bytes of that entry, waiting WAIT_CYCLES per byte to cover the access time.
- Assembles the bytes into one word and hands it downstream on a valid/ready handshake.

Parameters:
- ADDR_W, 16, EEPROM address width.
- DATA_W, 8, EEPROM data width.
- ENTRY_BYTES, 5, bytes per table entry; entry i starts at address i*ENTRY_BYTES.
- INDEX_W, 8, width of the table index.
- WAIT_CYCLES, 2, extra cycles each address is held before its byte is sampled; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- in_index  in  INDEX_W  table entry to fetch.
- rom_cs_n  out  1  EEPROM chip select, active low.
- rom_oe_n  out  1  EEPROM output enable, active low.
- rom_addr  out  ADDR_W  EEPROM address.
- rom_data  in  DATA_W  EEPROM data bus.
- out_valid  out  1  assembled word valid.
- out_ready  in  1  downstream accepts.
- out_word  out  ENTRY_BYTES*DATA_W  assembled entry.
- busy  out  1  high in READ or DONE.

Behaviour:
- Reset (synchronous, one edge):
  - state=IDLE, rom_cs_n=1, rom_oe_n=1, rom_addr=0.
  - out_valid=0, out_word=0, busy=0.
  - Internal byte and wait counters are cleared.
- State machine, registered, three states: IDLE, READ, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch base = in_index*ENTRY_BYTES, computed in ADDR_W bits and truncated modulo 2^ADDR_W.
  - Set rom_addr=base, rom_cs_n=0, rom_oe_n=0, byte_cnt=0, wait_cnt=0.
  - Go to READ.
- READ:
  - cs_n and oe_n stay low continuously for the whole fetch.
  - Each byte period is WAIT_CYCLES+1 cycles.
  - When wait_cnt==WAIT_CYCLES, sample rom_data into byte lane byte_cnt of the shadow word (lane k = bits [8k+7:8k]; lowest address in the least significant byte).
  - If byte_cnt==ENTRY_BYTES-1:
    - Copy the shadow word to out_word and set out_valid=1.
    - Raise rom_cs_n and rom_oe_n, then go to DONE.
  - Otherwise: increment byte_cnt, increment rom_addr (wraps modulo 2^ADDR_W), clear wait_cnt.
  - Otherwise, when wait_cnt<WAIT_CYCLES: increment wait_cnt only.
- DONE:
  - out_valid and out_word are held stable until out_valid&&out_ready.
  - On that edge: out_valid=0, go to IDLE. out_word keeps its last value.
- Latency: out_valid rises exactly ENTRY_BYTES*(WAIT_CYCLES+1) edges after the accepting edge, i.e. 15 with the defaults.
  - Minimum request-to-request spacing is that latency + 2.
- in_valid outside IDLE is ignored; no queuing.
- out_ready asserted while out_valid=0 has no effect.
- rom_addr holds its last value while cs_n=1.
- Reset mid-READ aborts the fetch; cs_n/oe_n are high from the next cycle and no partial word is presented.
- Reset wins over every simultaneous event.

Decomposition:
- Shared package base_conv_pkg holds:
  - the state enum (IDLE, READ, DONE);
  - ENTRY_BYTES = 5;
  - the EEPROM address and data width constants, shared with the EEPROM model and the converter.
- No sub-module; the wait/byte counters stay inline.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst for 2 cycles, then release.
  - Required: cs_n=1, oe_n=1, addr=0, out_valid=0, in_ready=1.
- Index 0, defaults, EEPROM model attached, out_ready=1:
  - Required: addresses 0..4, each held 3 cycles.
  - out_valid exactly 15 edges after accept, for 1 cycle.
  - out_word = 40'h120b040201.
- Index 1 with out_ready held low for 10 cycles:
  - Required: out_word = 40'hbc3cb44228 held stable and out_valid stays high throughout.
  - Clears on the cycle after out_ready rises.
- Index 2 with WAIT_CYCLES=0:
  - Required: one address per cycle (10..14), out_valid 5 edges after accept.
  - out_word = 40'hd02870b050.
- Back-to-back requests, in_valid held high:
  - Required: the second request is accepted only after DONE→IDLE.
  - Index 5 yields 40'h0000000000.
- rst asserted during the third byte of index 3:
  - Required: cs_n/oe_n high next cycle, no out_valid.
  - A subsequent index-3 fetch returns 40'h80a000f020.
